// File: rtl/ram_sweep.sv
// ram_sweep: single-port synchronous RAM, registered write-through read
// path, and an FSM that sweeps every word to FILL on a Clear request.
// Ports: clock, reset (async, active-high); enable/write/address/data_in
// host access; data_out/valid/addr_err registered response; clear
// starts a sweep, busy while sweeping, done pulses at sweep end.
// Option: define RAM_SWEEP_AUTOCLEAR_EN to sweep the RAM out of reset.
module ram_sweep #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              addr_err,
  input  logic              clear,
  output logic              busy,
  output logic              done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

`ifdef RAM_SWEEP_AUTOCLEAR_EN
  localparam state_t RST_ST = SWEEP;
`else
  localparam state_t RST_ST = IDLE;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_n;
  logic              done_n;

  logic              accept;
  logic              in_range;
  logic              acc_we;
  logic              sweep_we;

  assign busy     = (state == SWEEP);
  assign accept   = enable & ~busy;
  assign in_range = ({1'b0, address} < LIM);
  // Host writes are also blocked while reset is held, since the
  // storage array itself has no reset to protect it.
  assign acc_we   = accept & write & in_range & ~reset;
  assign sweep_we = busy;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_n = SWEEP;
        end
      end
      SWEEP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Storage: never reset. Sweep and host writes are exclusive
  // because host access is only accepted in IDLE.
  always_ff @(posedge clock) begin
    if (sweep_we) begin
      mem[cnt[IW-1:0]] <= FILL;
    end else if (acc_we) begin
      mem[address[IW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RST_ST;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      valid    <= 1'b0;
      addr_err <= 1'b0;
    end else if (accept) begin
      valid    <= 1'b1;
      addr_err <= ~in_range;
      if (!in_range) begin
        data_out <= '0;
      end else if (write) begin
        data_out <= data_in;
      end else begin
        data_out <= mem[address[IW-1:0]];
      end
    end else begin
      valid    <= 1'b0;
      addr_err <= 1'b0;
    end
  end

endmodule
